// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS core front end.
// Holds the IF/ID payload, the fetch state encoding and the word size.
package mips_pkg;

   localparam int unsigned INSTR_W    = 32;
   localparam logic [31:0] WORD_BYTES = 32'd4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FAULT = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [31:0]        pc;
      logic [31:0]        pc_plus4;
   } ifid_t;

endpackage

// File: rtl/pipe_reg_vr.sv
// Generic valid/ready payload register with a flush input.
// Flush beats a load; a load beats a consume.
module pipe_reg_vr #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   logic             valid_q;
   logic [WIDTH-1:0] data_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else if (flush) begin
         valid_q <= 1'b0;
      end else if (in_valid) begin
         valid_q <= 1'b1;
         data_q  <= in_data;
      end else if (valid_q && out_ready) begin
         valid_q <= 1'b0;
      end
   end

   assign in_ready  = !valid_q || out_ready;
   assign out_valid = valid_q;
   assign out_data  = data_q;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, addresses the instruction ROM and
// registers the fetched word toward decode; latches a sticky illegal-PC fault.
module ifetch_unit
   import mips_pkg::*;
#(
   parameter int unsigned ADDR_W   = 6,
   parameter int unsigned DATA_W   = 32,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              reset,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [DATA_W-1:0] imem_data,
   input  logic              redirect_valid,
   input  logic [31:0]       redirect_pc,
   output logic              if_valid,
   input  logic              if_ready,
   output logic [DATA_W-1:0] if_instr,
   output logic [31:0]       if_pc,
   output logic [31:0]       if_pc_plus4,
   output logic              fault
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic         fault_q, fault_d;
   logic         load, flush, out_free, pc_illegal;
   ifid_t        in_data, out_data;

   // The PC is never truncated, so running off the ROM end faults instead of aliasing.
   assign pc_illegal = (pc_q[1:0] != 2'b00) || (pc_q[31:ADDR_W+2] != '0);

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      fault_d = fault_q;
      load    = 1'b0;
      flush   = 1'b0;
      unique case (state_q)
         IDLE: state_d = RUN;
         RUN: begin
            if (redirect_valid) begin
               pc_d  = redirect_pc;
               flush = 1'b1;
            end else if (pc_illegal) begin
               fault_d = 1'b1;
               state_d = FAULT;
            end else if (out_free) begin
               load = 1'b1;
               pc_d = pc_q + WORD_BYTES;
            end
         end
         FAULT: state_d = FAULT;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         fault_q <= fault_d;
      end
   end

   always_comb begin
      in_data          = '0;
      in_data.instr    = imem_data;
      in_data.pc       = pc_q;
      in_data.pc_plus4 = pc_q + WORD_BYTES;
   end

   pipe_reg_vr #(
      .WIDTH($bits(ifid_t))
   ) u_ifid (
      .clk      (clk),
      .reset    (reset),
      .flush    (flush),
      .in_valid (load),
      .in_data  (in_data),
      .in_ready (out_free),
      .out_valid(if_valid),
      .out_ready(if_ready),
      .out_data (out_data)
   );

   assign imem_addr   = pc_q[ADDR_W+1:2];
   assign if_instr    = out_data.instr;
   assign if_pc       = out_data.pc;
   assign if_pc_plus4 = out_data.pc_plus4;
   assign fault       = fault_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed self-checking bench for ifetch_unit with a synthetic ROM
// returning 32'hA000_0000 | word_address.
module tb_ifetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [5:0]  imem_addr;
   logic [31:0] imem_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic [31:0] if_pc_plus4;
   logic        fault;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   assign imem_data = 32'hA000_0000 | {26'd0, imem_addr};

   ifetch_unit dut (
      .clk           (clk),
      .reset         (reset),
      .imem_addr     (imem_addr),
      .imem_data     (imem_data),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc),
      .if_valid      (if_valid),
      .if_ready      (if_ready),
      .if_instr      (if_instr),
      .if_pc         (if_pc),
      .if_pc_plus4   (if_pc_plus4),
      .fault         (fault)
   );

   // Advance one edge; outputs are sampled and inputs changed 1ns after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; if_ready = 1'b1;
      step(); step();
      checks++; if (if_valid !== 1'b0) begin
         failures++; $display("FAIL reset_valid got=%b want=0", if_valid); end
      checks++; if (if_instr !== 32'h0 || if_pc !== 32'h0 || if_pc_plus4 !== 32'h0) begin
         failures++;
         $display("FAIL reset_payload got=%h/%h/%h want=0/0/0", if_instr, if_pc, if_pc_plus4);
      end
      checks++; if (fault !== 1'b0 || imem_addr !== 6'd0) begin
         failures++; $display("FAIL reset_fault_addr got=%b/%0d want=0/0", fault, imem_addr); end
   endtask

   task automatic test_sequential();
      reset = 1'b0;
      step();
      checks++; if (if_valid !== 1'b0) begin
         failures++; $display("FAIL seq_idle_valid got=%b want=0", if_valid); end
      for (int k = 0; k < 3; k++) begin
         if (k != 0 || 1'b1) step();
         checks++;
         if (if_valid !== 1'b1 || if_pc !== 32'(4*k) || if_instr !== (32'hA000_0000 | 32'(k))
             || if_pc_plus4 !== 32'(4*k + 4)) begin
            failures++;
            $display("FAIL seq_word%0d got=%b/%h/%h/%h want=1/%h/%h/%h", k, if_valid, if_pc,
                     if_instr, if_pc_plus4, 32'(4*k), 32'hA000_0000 | 32'(k), 32'(4*k + 4));
         end
      end
   endtask

   task automatic test_backpressure();
      if_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (if_valid !== 1'b1 || if_pc !== 32'h8 || if_instr !== 32'hA000_0002
             || imem_addr !== 6'd3) begin
            failures++;
            $display("FAIL stall%0d got=%b/%h/%h/%0d want=1/8/a0000002/3", i, if_valid, if_pc,
                     if_instr, imem_addr);
         end
      end
      if_ready = 1'b1;
      step();
      checks++; if (if_valid !== 1'b1 || if_pc !== 32'hC || if_instr !== 32'hA000_0003) begin
         failures++;
         $display("FAIL stall_resume got=%b/%h/%h want=1/c/a0000003", if_valid, if_pc, if_instr);
      end
      step();
      checks++; if (if_pc !== 32'h10 || if_instr !== 32'hA000_0004) begin
         failures++; $display("FAIL stall_next got=%h/%h want=10/a0000004", if_pc, if_instr); end
   endtask

   task automatic test_redirect();
      if_ready = 1'b0;
      step();
      redirect_valid = 1'b1; redirect_pc = 32'h3C;
      step();
      redirect_valid = 1'b0; redirect_pc = 32'h0;
      checks++; if (if_valid !== 1'b0 || imem_addr !== 6'hF) begin
         failures++; $display("FAIL redir_flush got=%b/%0d want=0/15", if_valid, imem_addr); end
      step();
      checks++; if (if_valid !== 1'b1 || if_pc !== 32'h3C || if_instr !== 32'hA000_000F) begin
         failures++;
         $display("FAIL redir_target got=%b/%h/%h want=1/3c/a000000f", if_valid, if_pc, if_instr);
      end
      step();
      checks++; if (if_pc !== 32'h3C || if_pc_plus4 !== 32'h40) begin
         failures++; $display("FAIL redir_hold got=%h/%h want=3c/40", if_pc, if_pc_plus4); end
      if_ready = 1'b1;
   endtask

   task automatic test_end_of_rom();
      int n = 0;
      while (if_pc !== 32'hFC && n < 100) begin
         step();
         n++;
      end
      checks++; if (if_pc !== 32'hFC || if_instr !== 32'hA000_003F || fault !== 1'b0) begin
         failures++;
         $display("FAIL rom_last got=%h/%h/%b want=fc/a000003f/0", if_pc, if_instr, fault);
      end
      step();
      checks++; if (fault !== 1'b1 || if_valid !== 1'b0) begin
         failures++; $display("FAIL rom_fault got=%b/%b want=1/0", fault, if_valid); end
      redirect_valid = 1'b1; redirect_pc = 32'h10;
      step();
      redirect_valid = 1'b0;
      step();
      checks++; if (imem_addr !== 6'd0 || if_valid !== 1'b0 || fault !== 1'b1) begin
         failures++;
         $display("FAIL rom_redir_ignored got=%0d/%b/%b want=0/0/1", imem_addr, if_valid, fault);
      end
   endtask

   task automatic test_misaligned();
      reset = 1'b1;
      step();
      reset = 1'b0;
      step(); step();
      redirect_valid = 1'b1; redirect_pc = 32'h6;
      step();
      redirect_valid = 1'b0;
      checks++; if (if_valid !== 1'b0 || fault !== 1'b0 || imem_addr !== 6'd1) begin
         failures++;
         $display("FAIL mis_redir got=%b/%b/%0d want=0/0/1", if_valid, fault, imem_addr);
      end
      step();
      checks++; if (fault !== 1'b1 || if_valid !== 1'b0) begin
         failures++; $display("FAIL mis_fault got=%b/%b want=1/0", fault, if_valid); end
      reset = 1'b1;
      step();
      reset = 1'b0;
      checks++; if (fault !== 1'b0 || if_valid !== 1'b0) begin
         failures++; $display("FAIL mis_reset got=%b/%b want=0/0", fault, if_valid); end
      step();
      checks++; if (if_valid !== 1'b0) begin
         failures++; $display("FAIL mis_idle got=%b want=0", if_valid); end
      step();
      checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== 32'hA000_0000) begin
         failures++;
         $display("FAIL mis_resume got=%b/%h/%h want=1/0/a0000000", if_valid, if_pc, if_instr);
      end
   endtask

   task automatic test_reset_mid_stall();
      step();
      if_ready = 1'b0;
      step();
      checks++; if (if_valid !== 1'b1 || if_pc !== 32'h4) begin
         failures++; $display("FAIL mid_stall_pre got=%b/%h want=1/4", if_valid, if_pc); end
      reset = 1'b1;
      step();
      checks++;
      if (if_valid !== 1'b0 || if_pc !== 32'h0 || if_instr !== 32'h0 || if_pc_plus4 !== 32'h0
          || imem_addr !== 6'd0 || fault !== 1'b0) begin
         failures++;
         $display("FAIL mid_stall_reset got=%b/%h/%h/%h/%0d/%b want=0/0/0/0/0/0", if_valid,
                  if_pc, if_instr, if_pc_plus4, imem_addr, fault);
      end
      reset = 1'b0;
      if_ready = 1'b1;
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_backpressure();
      test_redirect();
      test_end_of_rom();
      test_misaligned();
      test_reset_mid_stall();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
